// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/grant and response bus
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32 fetch with one outstanding imem request and a one-entry IF/ID skid buffer
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_stall_i,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    if_fetch_stage_if.master    imem,
    output logic                ifid_valid_o,
    output logic [XLEN-1:0]     ifid_pc_o,
    output logic [XLEN-1:0]     ifid_instr_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
    logic            accept, resp, grant;

    assign accept = !ifid_valid_q || !id_stall_i;
    assign resp   = state_q == WAIT && imem.rvalid;
    assign grant  = imem.req && imem.gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= 32'h0000_0013;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    // A flushed request still owes a response, so it parks in DISCARD until rvalid drains it.
    always_comb begin
        state_d = redirect_valid_i ? ((state_q == IDLE || imem.rvalid) ? IDLE : DISCARD) :
                  grant ? WAIT :
                  (state_q != IDLE && imem.rvalid) ? IDLE : state_q;
    end

    always_comb begin
        imem.req  = !rst && !redirect_valid_i && !skid_valid_q && (state_q == IDLE || (resp && accept));
        imem.addr = pc_q;
    end

    always_comb begin
        pc_d         = redirect_valid_i ? {redirect_pc_i[XLEN-1:2], 2'b00} : grant ? pc_q + XLEN'(4) : pc_q;
        req_pc_d     = grant ? pc_q : req_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (redirect_valid_i) begin
            ifid_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!accept) begin
            if (resp) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_instr_d = imem.rdata;
            end
        end else if (skid_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
        end else begin
            ifid_valid_d = resp;
            ifid_pc_d    = resp ? req_pc_q : ifid_pc_q;
            ifid_instr_d = resp ? imem.rdata : ifid_instr_q;
        end
    end

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus random traffic against a transaction-level fetch model
module tb_if_fetch_stage;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    logic        clk = 1'b0;
    logic        rst, id_stall, redir;
    logic [31:0] rpc;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_instr;

    if_fetch_stage_if mi();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .id_stall_i(id_stall),
        .redirect_valid_i(redir),
        .redirect_pc_i(rpc),
        .imem(mi.master),
        .ifid_valid_o(ifid_valid),
        .ifid_pc_o(ifid_pc),
        .ifid_instr_o(ifid_instr)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, fails = 0;
    int unsigned gnt_pct = 100, rv_pct = 100;
    bit          mpend;
    logic [31:0] maddr;
    logic [31:0] m_pc, m_req_pc, m_ifpc, m_ifin;
    bit          m_ifv, m_busy, m_drop;
    logic [63:0] skid_q[$];
    logic        s_req;
    logic [31:0] s_addr;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_req_pc = 32'h0; m_ifv = 0; m_ifpc = 32'h0; m_ifin = 32'h13;
        m_busy = 0; m_drop = 0; skid_q.delete();
    endtask

    task automatic cyc();
        bit acc, exp_req, g, rv, live;
        logic [31:0] rd;
        logic [63:0] w;
        g = $urandom_range(99) < gnt_pct;
        rv = mpend && ($urandom_range(99) < rv_pct);
        rd = rv ? maddr ^ KEY : $urandom;
        mi.gnt = g; mi.rvalid = rv; mi.rdata = rd;
        #1;
        s_req = mi.req; s_addr = mi.addr;
        acc = !m_ifv || !id_stall;
        exp_req = !rst && !redir && skid_q.size() == 0 && (!m_busy || (!m_drop && rv && acc));
        check("imem_req", 32'(s_req), 32'(exp_req));
        if (exp_req) check("imem_addr", s_addr, m_pc);
        if (s_req && g) check("one_outstanding", 32'(mpend && !rv), 32'h0);
        @(posedge clk);
        if (rst) begin
            model_reset();
            mpend = 0;
        end else begin
            live = rv && m_busy && !m_drop;
            if (redir) begin
                m_ifv = 0;
                skid_q.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
                if (rv) begin m_busy = 0; m_drop = 0; end
                else if (m_busy) m_drop = 1;
            end else begin
                if (live && !acc) skid_q.push_back({m_req_pc, rd});
                else if (acc) begin
                    if (live) begin m_ifv = 1; m_ifpc = m_req_pc; m_ifin = rd; end
                    else if (skid_q.size() > 0) begin w = skid_q.pop_front(); m_ifv = 1; {m_ifpc, m_ifin} = w; end
                    else m_ifv = 0;
                end
                if (rv) begin m_busy = 0; m_drop = 0; end
                if (exp_req && g) begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; end
            end
            if (rv) mpend = 0;
            if (s_req && g) begin mpend = 1; maddr = s_addr; end
        end
        #1;
        check("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
        if (m_ifv) begin
            check("ifid_pc", ifid_pc, m_ifpc);
            check("ifid_instr", ifid_instr, m_ifin);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; id_stall = 0; redir = 0; rpc = 32'h0; gnt_pct = 100; rv_pct = 100;
        cyc(); cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1; id_stall = 0; redir = 0; rpc = 32'h0;
        mi.gnt = 0; mi.rvalid = 0; mi.rdata = 32'h0;
        mpend = 0; maddr = 32'h0;
        model_reset();
        @(negedge clk);
        // zero-wait streaming
        do_reset();
        check("rst_valid", 32'(ifid_valid), 32'h0);
        check("rst_pc", ifid_pc, 32'h0);
        check("rst_instr", ifid_instr, 32'h0000_0013);
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("zw_valid", 32'(ifid_valid), 32'h1);
            check("zw_pc", ifid_pc, 32'(4 * i));
        end
        // stall fills the skid, release drains in order
        do_reset();
        cyc(); cyc(); cyc();
        id_stall = 1;
        cyc(); check("stall_hold", ifid_pc, 32'h4);
        cyc(); check("stall_req", 32'(s_req), 32'h0); check("stall_hold", ifid_pc, 32'h4);
        cyc(); check("stall_req", 32'(s_req), 32'h0); check("stall_hold", ifid_pc, 32'h4);
        id_stall = 0;
        cyc(); check("drain_req", 32'(s_req), 32'h0); check("drain_pc", ifid_pc, 32'h8);
        cyc();
        cyc(); check("after_drain_valid", 32'(ifid_valid), 32'h1); check("after_drain_pc", ifid_pc, 32'hC);
        // redirect while waiting, late response dropped
        do_reset();
        rv_pct = 0;
        cyc();
        redir = 1; rpc = 32'h0000_0103;
        cyc(); check("redir_valid", 32'(ifid_valid), 32'h0);
        redir = 0;
        cyc(); check("discard_req", 32'(s_req), 32'h0);
        rv_pct = 100;
        cyc(); check("discard_drop", 32'(ifid_valid), 32'h0); check("discard_req", 32'(s_req), 32'h0);
        cyc(); check("redir_fetch_req", 32'(s_req), 32'h1); check("redir_fetch_addr", s_addr, 32'h0000_0100);
        // redirect coinciding with response under stall
        do_reset();
        cyc(); cyc();
        id_stall = 1; redir = 1; rpc = 32'h0000_0200;
        cyc(); check("redir_rv_valid", 32'(ifid_valid), 32'h0);
        id_stall = 0; redir = 0;
        cyc(); check("redir_rv_req", 32'(s_req), 32'h1); check("redir_rv_addr", s_addr, 32'h0000_0200);
        cyc(); check("redir_rv_pc", ifid_pc, 32'h0000_0200);
        // delayed grant keeps address stable
        do_reset();
        cyc(); cyc();
        gnt_pct = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); check("gnt_wait_req", 32'(s_req), 32'h1); check("gnt_wait_addr", s_addr, 32'h8);
        end
        gnt_pct = 100;
        cyc(); check("gnt_addr", s_addr, 32'h8);
        cyc(); check("post_gnt_addr", s_addr, 32'hC);
        // reset in WAIT, then PC wrap
        do_reset();
        rv_pct = 0;
        cyc(); cyc();
        rst = 1;
        cyc();
        rst = 0;
        check("mid_rst_valid", 32'(ifid_valid), 32'h0);
        gnt_pct = 0;
        cyc(); check("restart_addr", s_addr, 32'h0); check("restart_req", 32'(s_req), 32'h1);
        gnt_pct = 100; rv_pct = 100;
        redir = 1; rpc = 32'hFFFF_FFFF;
        cyc();
        redir = 0;
        cyc(); check("wrap_addr", s_addr, 32'hFFFF_FFFC);
        cyc(); check("wrapped_addr", s_addr, 32'h0); check("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap_instr", ifid_instr, 32'hFFFF_FFFC ^ KEY);
        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                gnt_pct = $urandom_range(100, 20);
                rv_pct = $urandom_range(100, 20);
            end
            id_stall = $urandom_range(3) == 0;
            redir = $urandom_range(15) == 0;
            rpc = $urandom;
            rst = $urandom_range(299) == 0;
            cyc();
        end
        rst = 0; redir = 0; id_stall = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
